// File: rtl/spirose_pkg.sv
// Shared types and defaults for the hall-sensor slice timing path.
// Latency: n/a (declarations only). Backpressure: n/a.
package spirose_pkg;

    localparam int SLICES_DEFAULT = 128;
    localparam int SLICE_W        = $clog2(SLICES_DEFAULT);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } hall_state_t;

endpackage

// File: rtl/hall_debouncer.sv
// Synchronizes the raw active-low hall input and accepts a level only after DEBOUNCE equal samples.
// Latency: 2 sync cycles + DEBOUNCE samples to hall_stable/fall. Backpressure: none, free-running.
module hall_debouncer #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic hall_n,
    output logic hall_stable,
    output logic fall
);

    localparam int            CW   = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            hall_stable <= 1'b1;
            cnt         <= '0;
            fall        <= 1'b0;
        end else begin
            sync1 <= hall_n;
            sync2 <= sync1;
            fall  <= 1'b0;
            // Any sample that agrees with the accepted level restarts the run.
            if (sync2 == hall_stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                hall_stable <= sync2;
                cnt         <= '0;
                fall        <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hall_slice_sync.sv
// Measures the rotor period from hall edges and spreads SLICES position_sync strobes evenly per turn.
// Latency: hall_n fall to turn_start = 3 + DEBOUNCE cycles. Backpressure: none, strobes are fire-and-forget.
module hall_slice_sync
    import spirose_pkg::*;
#(
    parameter int SLICES     = SLICES_DEFAULT,
    parameter int PERIOD_W   = 24,
    parameter int MIN_PERIOD = 1000,
    parameter int MAX_PERIOD = 2**24 - 1,
    parameter int DEBOUNCE   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hall_n,
    output logic                      position_sync,
    output logic                      turn_start,
    output logic [$clog2(SLICES)-1:0] slice_idx,
    output logic                      locked,
    output logic [PERIOD_W-1:0]       period
);

    localparam int                  SW       = $clog2(SLICES);
    localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P    = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W:0]   SLICES_A = (PERIOD_W + 1)'(SLICES);
    localparam logic [SW-1:0]       LAST_IDX = SW'(SLICES - 1);

    logic hall_stable;
    logic hall_fall;

    hall_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .clk         (clk),
        .rst         (rst),
        .hall_n      (hall_n),
        .hall_stable (hall_stable),
        .fall        (hall_fall)
    );

    hall_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W:0]   acc_q, acc_d;
    logic [PERIOD_W:0]   acc_t;
    logic [PERIOD_W-1:0] period_d;
    logic [SW-1:0]       idx_d;
    logic                ps_d;
    logic                ts_d;
    logic                edge_evt;
    logic                accept;
    logic                lost;

    // fall is only ever raised together with the debounced level going low.
    assign edge_evt = hall_fall & ~hall_stable;
    assign accept   = edge_evt && ((state_q == UNLOCKED) || (cnt_q >= MIN_P));
    assign lost     = (state_q != UNLOCKED) && (cnt_q == MAX_P);
    assign acc_t    = acc_q + SLICES_A;

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == MAX_P) ? cnt_q : cnt_q + 1'b1;
        acc_d    = acc_q;
        period_d = period;
        idx_d    = slice_idx;
        ps_d     = 1'b0;
        ts_d     = 1'b0;

        if (lost) begin
            state_d = UNLOCKED;
            acc_d   = '0;
            idx_d   = '0;
        end else if (accept) begin
            cnt_d = '0;
            if (state_q == UNLOCKED) begin
                state_d = ACQUIRE;
            end else begin
                // cnt restarts at 0 on the edge cycle, so the edge-to-edge distance is cnt+1.
                state_d  = LOCKED;
                period_d = cnt_q + 1'b1;
                acc_d    = '0;
                idx_d    = '0;
                ps_d     = 1'b1;
                ts_d     = 1'b1;
            end
        end else if (state_q == LOCKED) begin
            if (acc_t >= {1'b0, period}) begin
                acc_d = acc_t - {1'b0, period};
                // Hold on the last slice until the next edge if the rotor slows down.
                if (slice_idx != LAST_IDX) begin
                    idx_d = slice_idx + 1'b1;
                    ps_d  = 1'b1;
                end
            end else begin
                acc_d = acc_t;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= UNLOCKED;
            cnt_q         <= '0;
            acc_q         <= '0;
            period        <= '0;
            slice_idx     <= '0;
            position_sync <= 1'b0;
            turn_start    <= 1'b0;
            locked        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            period        <= period_d;
            slice_idx     <= idx_d;
            position_sync <= ps_d;
            turn_start    <= ts_d;
            locked        <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_hall_slice_sync.sv
// Randomized and scripted hall-pulse stimulus; expected strobes come from a turn-level model into a scoreboard.
module tb_hall_slice_sync;

    localparam int S     = 8;
    localparam int PW    = 24;
    localparam int MINP  = 100;
    localparam int MAXP  = 5000;
    localparam int DEB   = 4;
    localparam int LAT   = 3 + DEB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hall_n = 1'b1;
    logic          position_sync;
    logic          turn_start;
    logic [2:0]    slice_idx;
    logic          locked;
    logic [PW-1:0] period;

    hall_slice_sync #(
        .SLICES     (S),
        .PERIOD_W   (PW),
        .MIN_PERIOD (MINP),
        .MAX_PERIOD (MAXP),
        .DEBOUNCE   (DEB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hall_n        (hall_n),
        .position_sync (position_sync),
        .turn_start    (turn_start),
        .slice_idx     (slice_idx),
        .locked        (locked),
        .period        (period)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int idx;
        int ts;
        int per;
    } exp_t;

    exp_t exp_q[$];
    int   seg_d[$];
    int   seg_len[$];
    int   errors = 0;
    int   checks = 0;
    int   model_period = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe the DUT shows must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (position_sync || turn_start)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got idx %0d ts %0d, none expected at cycle %0d",
                         slice_idx, turn_start, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_time", cyc, e.t);
                chk("strobe_idx", int'(slice_idx), e.idx);
                chk("strobe_turn_start", int'(turn_start), e.ts);
                chk("strobe_position_sync", int'(position_sync), 1);
                chk("strobe_period", int'(period), e.per);
                chk("strobe_locked", int'(locked), 1);
            end
        end
    end

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // One turn of length per starting at start: slice j falls at start + ceil(j*per/S),
    // cut off by whatever ends the turn (next accepted edge, lock loss or reset).
    task automatic close_turn(input int start, input int per, input int end_t);
        for (int j = 0; j < S; j++) begin
            exp_t e;
            e.t   = start + ceil_div(j * per, S);
            e.idx = j;
            e.ts  = (j == 0) ? 1 : 0;
            e.per = per;
            if (e.t < end_t) exp_q.push_back(e);
        end
    endtask

    task automatic build_expect(input int base, input int reset_rel, output int end_t);
        int st;
        int last;
        int open;
        int o_start;
        int o_per;
        st = 0; last = 0; open = 0; o_start = 0; o_per = 0;
        for (int i = 0; i < seg_d.size(); i++) begin
            int ts;
            if (seg_len[i] < DEB) continue;
            ts = base + seg_d[i] + LAT;
            if (st != 0 && ts - last > MAXP) begin
                if (open != 0) close_turn(o_start, o_per, last + MAXP + 1);
                open = 0;
                st = 0;
            end
            if (st == 0) begin
                st = 1;
                last = ts;
            end else if (ts - last > MINP) begin
                if (open != 0) close_turn(o_start, o_per, ts);
                open = 1;
                o_start = ts;
                o_per = ts - last;
                model_period = o_per;
                st = 2;
                last = ts;
            end
        end
        end_t = (reset_rel >= 0) ? base + reset_rel : last + MAXP + 1;
        if (open != 0) close_turn(o_start, o_per, end_t);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_segment(input int reset_rel, input int rs_idx);
        int base;
        int end_t;
        base = cyc + 10;
        build_expect(base, reset_rel, end_t);
        for (int i = 0; i < seg_d.size(); i++) begin
            wait_cyc(base + seg_d[i]);
            hall_n = 1'b0;
            wait_cyc(base + seg_d[i] + seg_len[i]);
            hall_n = 1'b1;
        end
        if (reset_rel >= 0) begin
            wait_cyc(base + reset_rel);
            chk("pre_reset_position_sync", int'(position_sync), 1);
            chk("pre_reset_idx", int'(slice_idx), rs_idx);
            chk("pre_reset_queue_drained", exp_q.size(), 0);
            rst = 1'b1;
            #1;
            chk("mid_reset_position_sync", int'(position_sync), 0);
            chk("mid_reset_turn_start", int'(turn_start), 0);
            chk("mid_reset_idx", int'(slice_idx), 0);
            chk("mid_reset_locked", int'(locked), 0);
            chk("mid_reset_period", int'(period), 0);
            exp_q.delete();
            model_period = 0;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            wait_cyc(end_t + 20);
            chk("stall_queue_drained", exp_q.size(), 0);
            chk("stall_locked", int'(locked), 0);
            chk("stall_idx", int'(slice_idx), 0);
            chk("stall_position_sync", int'(position_sync), 0);
            chk("stall_period_held", int'(period), model_period);
            exp_q.delete();
        end
    endtask

    task automatic add_pulse(input int d, input int len);
        seg_d.push_back(d);
        seg_len.push_back(len);
    endtask

    task automatic clear_seg();
        seg_d.delete();
        seg_len.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_position_sync", int'(position_sync), 0);
        chk("reset_turn_start", int'(turn_start), 0);
        chk("reset_idx", int'(slice_idx), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_period", int'(period), 0);
        rst = 1'b0;

        // Lock at 800, then reset on the fourth strobe of the following turn.
        clear_seg();
        add_pulse(0, 20); add_pulse(800, 20); add_pulse(1600, 20);
        run_segment(1600 + LAT + 300, 3);

        // Relock after reset, steady 800, a 3-cycle glitch, an edge only 50 cycles late, then stall.
        clear_seg();
        add_pulse(0, 20); add_pulse(800, 20); add_pulse(1600, 20);
        add_pulse(1700, 3); add_pulse(2400, 20); add_pulse(2450, 20);
        add_pulse(3200, 20);
        run_segment(-1, 0);

        // Speed-up 800 -> 400, back to 800, slow-down to 1200, then stall.
        clear_seg();
        add_pulse(0, 20); add_pulse(800, 20); add_pulse(1600, 20);
        add_pulse(2000, 20); add_pulse(2400, 20); add_pulse(3200, 20);
        add_pulse(4400, 20); add_pulse(5200, 20);
        run_segment(-1, 0);

        for (int s = 0; s < 5; s++) begin
            int t;
            int n;
            clear_seg();
            t = 0;
            n = $urandom_range(3, 7);
            for (int i = 0; i < n; i++) begin
                int g;
                int r;
                add_pulse(t, 20);
                g = $urandom_range(150, 1500);
                r = $urandom_range(0, 3);
                if (r == 0) add_pulse(t + g / 2, 3);
                else if (r == 1) add_pulse(t + $urandom_range(40, 90), 20);
                t += g;
            end
            run_segment(-1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
